// File: rtl/fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_ctrl
// Description : Fetch/decode control stage for a single-cycle MIPS datapath.
//               Runs FETCH -> DECODE -> EXEC per instruction; enables fire in EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [3:0]  ALUcontrol,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic [31:0] pc,
    output logic [31:0] instr_count,
    output logic        illegal
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_DECODE = 3'd2;
    localparam logic [2:0] c_S_EXEC   = 3'd3;
    localparam logic [2:0] c_S_HALT   = 3'd4;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_NOP   = 6'b000000;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0101;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_instr_count;
    logic        r_illegal;

    logic        r_reg_dst;
    logic        r_alu_src;
    logic        r_mem_to_reg;
    logic [3:0]  r_alu_control;
    logic        r_dec_reg_write;
    logic        r_dec_mem_write;
    logic        r_dec_mem_read;

    logic        w_dec_legal;
    logic        w_dec_reg_dst;
    logic        w_dec_alu_src;
    logic        w_dec_mem_to_reg;
    logic [3:0]  w_dec_alu_control;
    logic        w_dec_reg_write;
    logic        w_dec_mem_write;
    logic        w_dec_mem_read;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_in_exec;

    assign w_op      = r_instruction[31:26];
    assign w_funct   = r_instruction[5:0];
    assign w_in_exec = (r_state == c_S_EXEC);

    // Unsupported encodings leave every control at 0 with legal cleared.
    always_comb begin
        w_dec_legal       = 1'b0;
        w_dec_reg_dst     = 1'b0;
        w_dec_alu_src     = 1'b0;
        w_dec_mem_to_reg  = 1'b0;
        w_dec_alu_control = 4'b0000;
        w_dec_reg_write   = 1'b0;
        w_dec_mem_write   = 1'b0;
        w_dec_mem_read    = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_NOP: begin
                        w_dec_legal = 1'b1;
                    end
                    c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: begin
                        w_dec_legal     = 1'b1;
                        w_dec_reg_dst   = 1'b1;
                        w_dec_reg_write = 1'b1;
                        case (w_funct)
                            c_FN_ADD: w_dec_alu_control = c_ALU_ADD;
                            c_FN_SUB: w_dec_alu_control = c_ALU_SUB;
                            c_FN_AND: w_dec_alu_control = c_ALU_AND;
                            c_FN_OR:  w_dec_alu_control = c_ALU_OR;
                            default:  w_dec_alu_control = c_ALU_SLT;
                        endcase
                    end
                    default: ;
                endcase
            end
            c_OP_LW: begin
                w_dec_legal       = 1'b1;
                w_dec_alu_src     = 1'b1;
                w_dec_mem_to_reg  = 1'b1;
                w_dec_alu_control = c_ALU_ADD;
                w_dec_reg_write   = 1'b1;
                w_dec_mem_read    = 1'b1;
            end
            c_OP_SW: begin
                w_dec_legal       = 1'b1;
                w_dec_alu_src     = 1'b1;
                w_dec_alu_control = c_ALU_ADD;
                w_dec_mem_write   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (en) w_state_nxt = c_S_FETCH;
            c_S_FETCH:  if (imem_ready) w_state_nxt = c_S_DECODE;
            c_S_DECODE: w_state_nxt = w_dec_legal ? c_S_EXEC : c_S_HALT;
            c_S_EXEC:   w_state_nxt = en ? c_S_FETCH : c_S_IDLE;
            c_S_HALT:   w_state_nxt = c_S_HALT;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_instruction   <= 32'h0;
            r_instr_count   <= 32'h0;
            r_illegal       <= 1'b0;
            r_reg_dst       <= 1'b0;
            r_alu_src       <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_control   <= 4'b0000;
            r_dec_reg_write <= 1'b0;
            r_dec_mem_write <= 1'b0;
            r_dec_mem_read  <= 1'b0;
        end else begin
            case (r_state)
                c_S_FETCH: begin
                    if (imem_ready) begin
                        r_instruction <= imem_rdata;
                    end
                end
                c_S_DECODE: begin
                    r_reg_dst       <= w_dec_reg_dst;
                    r_alu_src       <= w_dec_alu_src;
                    r_mem_to_reg    <= w_dec_mem_to_reg;
                    r_alu_control   <= w_dec_alu_control;
                    r_dec_reg_write <= w_dec_reg_write;
                    r_dec_mem_write <= w_dec_mem_write;
                    r_dec_mem_read  <= w_dec_mem_read;
                    if (!w_dec_legal) begin
                        r_illegal <= 1'b1;
                    end
                end
                c_S_EXEC: begin
                    r_pc          <= r_pc + 32'(PC_STEP);
                    r_instr_count <= r_instr_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Write enables are qualified by EXEC so they commit for exactly one cycle.
    assign RegWrite    = r_dec_reg_write & w_in_exec;
    assign MemWrite    = r_dec_mem_write & w_in_exec;
    assign MemRead     = r_dec_mem_read  & w_in_exec;

    assign RegDst      = r_reg_dst;
    assign ALUSrc      = r_alu_src;
    assign MemToReg    = r_mem_to_reg;
    assign ALUcontrol  = r_alu_control;

    assign imem_req    = (r_state == c_S_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instruction;
    assign instr_count = r_instr_count;
    assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_ctrl
// Description : Randomized self-checking bench for fetch_decode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, illegal;
    logic [3:0]  ALUcontrol;
    logic [31:0] imem_addr, instruction, pc, instr_count;

    logic        en_w, imem_ready_w;
    logic [31:0] imem_rdata_w;
    logic        imem_req_w, RegDst_w, RegWrite_w, ALUSrc_w, MemWrite_w, MemRead_w, MemToReg_w, illegal_w;
    logic [3:0]  ALUcontrol_w;
    logic [31:0] imem_addr_w, instruction_w, pc_w, instr_count_w;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    fetch_decode_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .ALUcontrol(ALUcontrol), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg), .pc(pc),
        .instr_count(instr_count), .illegal(illegal)
    );

    fetch_decode_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst), .en(en_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ready(imem_ready_w), .imem_rdata(imem_rdata_w),
        .instruction(instruction_w), .RegDst(RegDst_w), .RegWrite(RegWrite_w),
        .ALUSrc(ALUSrc_w), .ALUcontrol(ALUcontrol_w), .MemWrite(MemWrite_w),
        .MemRead(MemRead_w), .MemToReg(MemToReg_w), .pc(pc_w),
        .instr_count(instr_count_w), .illegal(illegal_w)
    );

    // Reference decode: {legal, RegDst, ALUSrc, MemToReg, ALUcontrol[3:0], RegWrite, MemWrite, MemRead}
    function automatic logic [10:0] model(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00 && fn == 6'h20) return {1'b1, 3'b100, 4'b0101, 3'b100};
        if (op == 6'h00 && fn == 6'h22) return {1'b1, 3'b100, 4'b0110, 3'b100};
        if (op == 6'h00 && fn == 6'h24) return {1'b1, 3'b100, 4'b0000, 3'b100};
        if (op == 6'h00 && fn == 6'h25) return {1'b1, 3'b100, 4'b0001, 3'b100};
        if (op == 6'h00 && fn == 6'h2A) return {1'b1, 3'b100, 4'b0111, 3'b100};
        if (op == 6'h23)                return {1'b1, 3'b011, 4'b0101, 3'b101};
        if (op == 6'h2B)                return {1'b1, 3'b010, 4'b0101, 3'b010};
        if (op == 6'h00 && fn == 6'h00) return {1'b1, 3'b000, 4'b0000, 3'b000};
        return 11'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fns [5];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        r = $urandom;
        case ($urandom_range(0, 7))
            0, 1, 2: return {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
            3, 4:    return {6'h23, r[25:0]};
            5, 6:    return {6'h2B, r[25:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
    endtask

    // Entry: DUT in FETCH. Exit: one cycle after EXEC (FETCH if en_next, else IDLE).
    task automatic do_instr(input logic [31:0] word, input int delay, input logic en_next);
        logic [10:0] e;
        e = model(word);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_entry: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_pc);
        end
        for (int d = 0; d < delay; d++) begin
            imem_ready = 1'b0; imem_rdata = $urandom; en = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || {RegWrite, MemWrite, MemRead} !== 3'b000) begin
                errors++;
                $display("FAIL fetch_wait: req=%b addr=%h en=%b expected req=1 addr=%h en=000",
                         imem_req, imem_addr, {RegWrite, MemWrite, MemRead}, exp_pc);
            end
        end
        imem_ready = 1'b1; imem_rdata = word;
        step();
        checks++;
        if (instruction !== word || imem_req !== 1'b0 || {RegWrite, MemWrite, MemRead} !== 3'b000) begin
            errors++;
            $display("FAIL decode_cycle: instr=%h req=%b en=%b expected instr=%h req=0 en=000",
                     instruction, imem_req, {RegWrite, MemWrite, MemRead}, word);
        end
        imem_rdata = $urandom; en = en_next;
        step();
        checks++;
        if ({RegDst, ALUSrc, MemToReg, ALUcontrol, RegWrite, MemWrite, MemRead} !== e[9:0]
            || pc !== exp_pc || instruction !== word) begin
            errors++;
            $display("FAIL exec_ctrl: ctrl=%b pc=%h instr=%h expected ctrl=%b pc=%h instr=%h",
                     {RegDst, ALUSrc, MemToReg, ALUcontrol, RegWrite, MemWrite, MemRead}, pc, instruction,
                     e[9:0], exp_pc, word);
        end
        imem_ready = 1'b0;
        step();
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (pc !== exp_pc || instr_count !== exp_cnt || {RegWrite, MemWrite, MemRead} !== 3'b000
            || {RegDst, ALUSrc, MemToReg, ALUcontrol} !== e[9:3] || imem_req !== en_next) begin
            errors++;
            $display("FAIL retire: pc=%h cnt=%0d en=%b sel=%b req=%b expected pc=%h cnt=%0d en=000 sel=%b req=%b",
                     pc, instr_count, {RegWrite, MemWrite, MemRead}, {RegDst, ALUSrc, MemToReg, ALUcontrol},
                     imem_req, exp_pc, exp_cnt, e[9:3], en_next);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0 || instr_count !== 32'h0
                || illegal !== 1'b0
                || {RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg} !== 10'b0) begin
                errors++;
                $display("FAIL reset_idle: req=%b pc=%h instr=%h cnt=%0d ill=%b ctrl=%b expected all zero",
                         imem_req, pc, instruction, instr_count, illegal,
                         {RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg});
            end
        end
    endtask

    task automatic test_add();
        apply_reset();
        en = 1'b1;
        step();
        do_instr(32'h0043_0820, 0, 1'b0);
        checks++;
        if (pc !== 32'd4 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL add_retire: pc=%h cnt=%0d expected pc=00000004 cnt=1", pc, instr_count);
        end
    endtask

    task automatic test_lw_sw();
        apply_reset();
        en = 1'b1;
        step();
        do_instr(32'h8C44_0000, 3, 1'b1);
        do_instr(32'hAC41_0000, 3, 1'b0);
        checks++;
        if (pc !== 32'd8 || instr_count !== 32'd2) begin
            errors++;
            $display("FAIL lw_sw_retire: pc=%h cnt=%0d expected pc=00000008 cnt=2", pc, instr_count);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        en = 1'b1;
        step();
        imem_ready = 1'b1; imem_rdata = 32'hFC00_0000;
        step();
        imem_ready = 1'b0;
        checks++;
        if ({RegWrite, MemWrite, MemRead} !== 3'b000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_decode: en=%b ill=%b expected en=000 ill=0",
                     {RegWrite, MemWrite, MemRead}, illegal);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (illegal !== 1'b1 || imem_req !== 1'b0 || {RegWrite, MemWrite, MemRead} !== 3'b000
                || pc !== 32'h0 || instr_count !== 32'h0) begin
                errors++;
                $display("FAIL halt_hold: ill=%b req=%b en=%b pc=%h cnt=%0d expected ill=1 req=0 en=000 pc=0 cnt=0",
                         illegal, imem_req, {RegWrite, MemWrite, MemRead}, pc, instr_count);
            end
            en = 1'($urandom_range(0, 1)); imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        end
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0; imem_ready = 1'b0;
        checks++;
        if (illegal !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: ill=%b req=%b expected ill=0 req=0", illegal, imem_req);
        end
    endtask

    task automatic test_reset_in_fetch();
        apply_reset();
        en = 1'b1;
        step();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0043_0820;
        step();
        checks++;
        if (instruction !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_fetch: instr=%h pc=%h req=%b expected instr=0 pc=0 req=0",
                     instruction, pc, imem_req);
        end
        rst = 1'b0; en = 1'b0;
        step();
        checks++;
        if (instruction !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: instr=%h req=%b expected instr=0 req=0", instruction, imem_req);
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        logic in_fetch;
        logic en_next;
        apply_reset();
        in_fetch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!in_fetch) begin
                en = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    step();
                    checks++;
                    if (imem_req !== 1'b0 || pc !== exp_pc) begin
                        errors++;
                        $display("FAIL random_idle: req=%b pc=%h expected req=0 pc=%h", imem_req, pc, exp_pc);
                    end
                end
                en = 1'b1;
                step();
            end
            en_next = ($urandom_range(0, 3) != 0);
            do_instr(rand_instr(), $urandom_range(0, 3), en_next);
            in_fetch = en_next;
        end
        en = 1'b0;
    endtask

    task automatic test_pc_wrap();
        en_w = 1'b1;
        step();
        checks++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_fetch: req=%b addr=%h expected req=1 addr=fffffffc", imem_req_w, imem_addr_w);
        end
        imem_ready_w = 1'b1; imem_rdata_w = 32'h0043_0820;
        step();
        imem_ready_w = 1'b0; en_w = 1'b0;
        step();
        checks++;
        if (RegWrite_w !== 1'b1 || RegDst_w !== 1'b1 || ALUcontrol_w !== 4'b0101) begin
            errors++;
            $display("FAIL wrap_exec: rw=%b rd=%b alu=%b expected rw=1 rd=1 alu=0101",
                     RegWrite_w, RegDst_w, ALUcontrol_w);
        end
        step();
        checks++;
        if (pc_w !== 32'h0 || instr_count_w !== 32'd1 || illegal_w !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h cnt=%0d ill=%b expected pc=00000000 cnt=1 ill=0",
                     pc_w, instr_count_w, illegal_w);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        en_w = 1'b0; imem_ready_w = 1'b0; imem_rdata_w = 32'h0;
        exp_pc = 32'h0; exp_cnt = 32'h0;
        test_reset();
        test_add();
        test_lw_sw();
        test_illegal();
        test_reset_in_fetch();
        test_random_stream();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
